// File: rtl/inst_fetch_queue_unit.sv
// inst_fetch_queue_unit
// Fetch front end: issues one bundle request at a time, tags every returned bundle
// with a slot-valid mask cut after the first branch, and buffers bundles in a
// circular queue drained by the decoder through a valid/ready handshake. A branch
// parks fetch until redirect_valid_in supplies a new PC; the redirect also flushes
// the queue and retires any response still owed to the killed request.
//
// Ports
//   clk_in, reset_n_in          clock (rising edge), asynchronous active-low reset
//   fetch_addr_out/_valid_out   bundle request toward instruction memory
//   fetch_ack_in                memory accepted the request
//   fetch_data_in/_valid_in     returned bundle (slot 0 in LSBs), one-cycle pulse
//   redirect_valid_in/_pc_in    flush strobe and new fetch PC
//   insts_out/_mask_out/_pc_out head bundle, per-slot valid, PC of slot 0
//   insts_valid_out/_ready_in   decoder handshake
//
// Build option
//   FETCH_BYPASS_EN  when defined, a bundle arriving into an empty queue while the
//                    decoder is ready is forwarded combinationally and not stored.
//
// Branch detection treats the RV32 control-transfer major opcodes (BRANCH, JAL,
// JALR) as branches; only inst[6:0] of each slot is inspected.
module inst_fetch_queue_unit #(
  parameter int unsigned            NUM_SLOTS   = 2,
  parameter int unsigned            INST_WIDTH  = 32,
  parameter int unsigned            QUEUE_DEPTH = 4,
  parameter int unsigned            PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]    PC_RESET    = '0
) (
  input  logic                              clk_in,
  input  logic                              reset_n_in,
  output logic [PC_WIDTH-1:0]               fetch_addr_out,
  output logic                              fetch_addr_valid_out,
  input  logic                              fetch_ack_in,
  input  logic [NUM_SLOTS*INST_WIDTH-1:0]   fetch_data_in,
  input  logic                              fetch_data_valid_in,
  input  logic                              redirect_valid_in,
  input  logic [PC_WIDTH-1:0]               redirect_pc_in,
  output logic [NUM_SLOTS*INST_WIDTH-1:0]   insts_out,
  output logic [NUM_SLOTS-1:0]              insts_mask_out,
  output logic [PC_WIDTH-1:0]               insts_pc_out,
  output logic                              insts_valid_out,
  input  logic                              insts_ready_in
);

  localparam int unsigned BundleW = NUM_SLOTS * INST_WIDTH;
  localparam int unsigned IdxW    = $clog2(QUEUE_DEPTH);
  localparam int unsigned PtrW    = IdxW + 1;
  localparam logic [PC_WIDTH-1:0] PcInc = PC_WIDTH'(NUM_SLOTS * INST_WIDTH / 8);

  typedef enum logic [1:0] {StReq, StWait, StBrHold} state_e;

  function automatic logic is_br_op(input logic [6:0] op);
    return (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
  endfunction

  state_e              r_state, w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_drop;
  logic [PtrW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [BundleW-1:0]   r_q_data [QUEUE_DEPTH];
  logic [NUM_SLOTS-1:0] r_q_mask [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0]  r_q_pc   [QUEUE_DEPTH];

  logic                 w_empty, w_full, w_req, w_resp, w_bypass, w_push, w_pop;
  logic                 w_head_valid, w_kill, w_has_br;
  logic [NUM_SLOTS-1:0] w_mask;
  logic [IdxW-1:0]      w_wr_idx, w_rd_idx;

  assign w_wr_idx = r_wr_ptr[IdxW-1:0];
  assign w_rd_idx = r_rd_ptr[IdxW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[IdxW] != r_rd_ptr[IdxW]) && (w_wr_idx == w_rd_idx);

  // Slots up to and including the first branch are valid.
  always_comb begin
    logic found;
    found  = 1'b0;
    w_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_mask[i] = ~found;
      if (is_br_op(fetch_data_in[i*INST_WIDTH +: 7])) found = 1'b1;
    end
    w_has_br = found;
  end

  // A bundle is taken only in WAIT, when it is not owed to a killed request and
  // no redirect is flushing this cycle.
  assign w_resp = fetch_data_valid_in && (r_state == StWait) && !r_drop && !redirect_valid_in;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_resp && w_empty && insts_ready_in;
`else
  assign w_bypass = 1'b0;
`endif

  // Requests are only raised with a free entry and only one bundle is ever in
  // flight, so a push never meets a full queue.
  assign w_push       = w_resp && !w_bypass;
  assign w_head_valid = !w_empty;
  assign w_pop        = w_head_valid && insts_ready_in && !redirect_valid_in;

  // On redirect, remember whether a response for the killed request is still owed:
  // one outstanding in WAIT, one accepted this very cycle, or an older one not yet seen.
  assign w_kill = ((r_state == StWait) && (!fetch_data_valid_in || r_drop)) ||
                  (w_req && fetch_ack_in) ||
                  (r_drop && !fetch_data_valid_in);

  // State register
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) r_state <= StReq;
    else             r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StReq:    if (w_req && fetch_ack_in) w_state_next = StWait;
      StWait:   if (w_resp) w_state_next = w_has_br ? StBrHold : StReq;
      StBrHold: w_state_next = StBrHold;
      default:  w_state_next = StReq;
    endcase
    if (redirect_valid_in) w_state_next = StReq;
  end

  // FSM outputs; the request is held low while reset is asserted.
  always_comb begin
    w_req                = (r_state == StReq) && !w_full;
    fetch_addr_valid_out = w_req && reset_n_in;
  end

  assign fetch_addr_out = r_pc;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_pc     <= PC_RESET;
      r_drop   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (redirect_valid_in) begin
      r_pc     <= redirect_pc_in;
      r_drop   <= w_kill;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_resp && !w_has_br)          r_pc     <= r_pc + PcInc;
      if (fetch_data_valid_in && r_drop) r_drop   <= 1'b0;
      if (w_push)                       r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)                        r_rd_ptr <= r_rd_ptr + PtrW'(1);
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (w_push && !redirect_valid_in) begin
      r_q_data[w_wr_idx] <= fetch_data_in;
      r_q_mask[w_wr_idx] <= w_mask;
      r_q_pc[w_wr_idx]   <= r_pc;
    end
  end

  // Decoder side: head entry, zeroed when nothing is valid.
  always_comb begin
    insts_valid_out = w_head_valid || w_bypass;
    insts_out       = '0;
    insts_mask_out  = '0;
    insts_pc_out    = '0;
    if (w_head_valid) begin
      insts_out      = r_q_data[w_rd_idx];
      insts_mask_out = r_q_mask[w_rd_idx];
      insts_pc_out   = r_q_pc[w_rd_idx];
    end
`ifdef FETCH_BYPASS_EN
    else if (w_bypass) begin
      insts_out      = fetch_data_in;
      insts_mask_out = w_mask;
      insts_pc_out   = r_pc;
    end
`endif
  end

endmodule
